// File: rtl/calc_pkg.sv
// Shared definitions for the calculadora front end: state encodings, op codes
// and operand width.
package calc_pkg;

   localparam int W_OPER = 3;

   typedef enum logic [1:0] {
      ESPERA_A  = 2'b00,
      ESPERA_B  = 2'b01,
      ESPERA_OP = 2'b10,
      PRONTO    = 2'b11
   } estado_t;

   localparam logic [1:0] OP_SOMA = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_PROD = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

endpackage

// File: rtl/debounce_botao.sv
// Push-button conditioning: 2-FF synchronizer, optional stability filter
// (enabled by DEBOUNCE_EN) and a registered one-cycle rising-edge pulse.
module debounce_botao #(
   parameter int DEB_CYCLES = 50000,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic filt;
   logic filt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= btn;
         sync_2 <= sync_1;
      end
   end

`ifdef DEBOUNCE_EN
   logic             sync_3;
   logic [CNT_W-1:0] cnt;

   // cnt counts consecutive cycles with an unchanged synced level; the filter
   // only takes the new level once the count has reached DEB_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_3 <= 1'b0;
         cnt    <= '0;
         filt   <= 1'b0;
      end else begin
         sync_3 <= sync_2;
         if (sync_2 != sync_3)
            cnt <= '0;
         else if (cnt != CNT_W'(DEB_CYCLES))
            cnt <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(DEB_CYCLES))
            filt <= sync_3;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (DEB_CYCLES > 0) && (CNT_W > 0);
   assign filt       = sync_2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_d <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         filt_d <= filt;
         pulse  <= filt & ~filt_d;
      end
   end

endmodule

// File: rtl/controle_entrada.sv
// Operand-entry controller for calculadora: captures A, B and the operation
// on confirm presses. Button filtering is selected with DEBOUNCE_EN.
//
// state     | meaning
// ESPERA_A  | waiting for confirm to capture operand A
// ESPERA_B  | waiting for confirm to capture operand B
// ESPERA_OP | waiting for confirm to capture operation, then raise valid
// PRONTO    | request valid; next confirm drops valid and restarts
module controle_entrada
   import calc_pkg::*;
#(
   parameter int DEB_CYCLES = 50000,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [W_OPER-1:0] sw_dado,
   input  logic [1:0]        sw_op,
   input  logic              btn_ok,
   input  logic              btn_clr,
   output logic [W_OPER-1:0] A,
   output logic [W_OPER-1:0] B,
   output logic [1:0]        sel,
   output logic              valid,
   output logic [1:0]        estado,
   output logic              erro_div
);

   logic              ok_p;
   logic              clr_p;
   logic [W_OPER-1:0] dado_s1, dado_s2;
   logic [1:0]        op_s1, op_s2;
   estado_t           st;

   debounce_botao #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_ok (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_ok),
      .pulse (ok_p)
   );

   debounce_botao #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_clr),
      .pulse (clr_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dado_s1 <= '0;
         dado_s2 <= '0;
         op_s1   <= '0;
         op_s2   <= '0;
      end else begin
         dado_s1 <= sw_dado;
         dado_s2 <= dado_s1;
         op_s1   <= sw_op;
         op_s2   <= op_s1;
      end
   end

   // Clear has priority over confirm when both pulses land together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= ESPERA_A;
         A     <= '0;
         B     <= '0;
         sel   <= OP_SOMA;
         valid <= 1'b0;
      end else if (clr_p) begin
         st    <= ESPERA_A;
         A     <= '0;
         B     <= '0;
         sel   <= OP_SOMA;
         valid <= 1'b0;
      end else if (ok_p) begin
         case (st)
            ESPERA_A: begin
               A  <= dado_s2;
               st <= ESPERA_B;
            end
            ESPERA_B: begin
               B  <= dado_s2;
               st <= ESPERA_OP;
            end
            ESPERA_OP: begin
               sel   <= op_s2;
               valid <= 1'b1;
               st    <= PRONTO;
            end
            PRONTO: begin
               valid <= 1'b0;
               st    <= ESPERA_A;
            end
            default: st <= ESPERA_A;
         endcase
      end
   end

   assign estado   = st;
   assign erro_div = valid & (sel == OP_DIV) & (B == '0);

endmodule
